// File: rtl/int_to_float_if.sv
// int_to_float_if: operand/result bus with exec/done strobe handshake.
//   a_value_i     : signed 32-bit integer operand
//   exec_strobe_i : start strobe, honoured only when the converter is idle
//   z_value_o     : IEEE-754 single-precision result
//   done_strobe_o : one-cycle pulse, result valid on z_value_o
// master = sequencer side, slave = converter side.
interface int_to_float_if;
  logic [31:0] a_value_i;
  logic        exec_strobe_i;
  logic [31:0] z_value_o;
  logic        done_strobe_o;

  modport master (
    output a_value_i,
    output exec_strobe_i,
    input  z_value_o,
    input  done_strobe_o
  );

  modport slave (
    input  a_value_i,
    input  exec_strobe_i,
    output z_value_o,
    output done_strobe_o
  );
endinterface

// File: rtl/int_to_float.sv
// int_to_float: multi-cycle signed int32 -> IEEE-754 single converter,
// round-to-nearest-even. Feeds the FPU multiplier operands.
// Ports:
//   clk     : system clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : int_to_float_if.slave (a_value_i, exec_strobe_i, z_value_o, done_strobe_o)
// Build option:
//   ITOF_FAST_NORMALISE_EN : single-cycle normalise through a leading-zero
//                            count instead of one shift per cycle.
module int_to_float (
  input  logic           clk,
  input  logic           reset_i,
  int_to_float_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    DONE
  } state_t;

  localparam int unsigned W_DATA = 32;
  localparam int unsigned W_EXP  = 8;
  localparam int unsigned W_FRAC = 23;

  state_t              r_state, w_state_nxt;
  logic [W_DATA-1:0]   r_op, w_op_nxt;
  logic                r_z_s, w_z_s_nxt;
  logic [W_DATA-1:0]   r_z_m, w_z_m_nxt;
  logic [W_EXP-1:0]    r_z_e, w_z_e_nxt;
  logic [W_FRAC-1:0]   r_frac, w_frac_nxt;
  logic [W_DATA-1:0]   r_z_value, w_z_value_nxt;
  logic                r_done, w_done_nxt;

  logic [W_DATA-1:0]   w_abs;
  logic                w_guard;
  logic                w_round;
  logic                w_sticky;
  logic                w_round_up;
  logic [W_FRAC:0]     w_frac_inc;

  // |operand|; 0x80000000 maps to itself and is read as unsigned
  assign w_abs = r_op[W_DATA-1] ? W_DATA'(32'd0 - r_op) : r_op;

  // Leading one sits in z_m[31]; the stored fraction is z_m[30:8]
  assign w_guard    = r_z_m[7];
  assign w_round    = r_z_m[6];
  assign w_sticky   = |r_z_m[5:0];
  assign w_round_up = w_guard & (w_round | w_sticky | r_z_m[8]);
  // Carry out of the fraction means the 24-bit mantissa was all ones
  assign w_frac_inc = {1'b0, r_z_m[30:8]} + 24'd1;

`ifdef ITOF_FAST_NORMALISE_EN
  logic [4:0] w_lz;

  // Leading-zero count of z_m (z_m is nonzero whenever it is used)
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_z_m[i]) w_lz = 5'(31 - i);
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_z_s     <= 1'b0;
      r_z_m     <= '0;
      r_z_e     <= '0;
      r_frac    <= '0;
      r_z_value <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_z_s     <= w_z_s_nxt;
      r_z_m     <= w_z_m_nxt;
      r_z_e     <= w_z_e_nxt;
      r_frac    <= w_frac_nxt;
      r_z_value <= w_z_value_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_z_s_nxt     = r_z_s;
    w_z_m_nxt     = r_z_m;
    w_z_e_nxt     = r_z_e;
    w_frac_nxt    = r_frac;
    w_z_value_nxt = r_z_value;
    w_done_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.exec_strobe_i) begin
          w_op_nxt    = bus.a_value_i;
          w_state_nxt = CONVERT;
        end
      end

      CONVERT: begin
        if (r_op == '0) begin
          w_z_value_nxt = '0;
          w_state_nxt   = DONE;
        end else begin
          w_z_s_nxt   = r_op[W_DATA-1];
          w_z_m_nxt   = w_abs;
          w_z_e_nxt   = 8'd31;
          w_state_nxt = NORMALISE;
        end
      end

      NORMALISE: begin
`ifdef ITOF_FAST_NORMALISE_EN
        w_z_m_nxt   = r_z_m << w_lz;
        w_z_e_nxt   = 8'd31 - W_EXP'(w_lz);
        w_state_nxt = ROUND;
`else
        if (!r_z_m[W_DATA-1]) begin
          w_z_m_nxt = r_z_m << 1;
          w_z_e_nxt = r_z_e - 8'd1;
        end else begin
          w_state_nxt = ROUND;
        end
`endif
      end

      ROUND: begin
        if (w_round_up) begin
          w_frac_nxt = w_frac_inc[W_FRAC-1:0];
          // Mantissa wrapped to 1.0: bump the exponent
          if (w_frac_inc[W_FRAC]) w_z_e_nxt = r_z_e + 8'd1;
        end else begin
          w_frac_nxt = r_z_m[30:8];
        end
        w_state_nxt = PACK;
      end

      PACK: begin
        w_z_value_nxt = {r_z_s, W_EXP'(r_z_e + 8'd127), r_frac};
        w_state_nxt   = DONE;
      end

      DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.z_value_o     = r_z_value;
  assign bus.done_strobe_o = r_done;

endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: scoreboard bench for int_to_float. Expected result and
// latency are queued when a conversion is started and checked when the
// done pulse appears.
module tb_int_to_float;

  typedef struct {
    logic [31:0] z;
    int          start;
    int          lat;
    string       tag;
  } exp_t;

  logic clk;
  logic reset_i;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  int_to_float_if bus ();

  int_to_float u_dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Independent reference: position of the top bit, then RNE on the dropped bits
  function automatic int msb_pos(input logic [31:0] mag);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    return p;
  endfunction

  function automatic logic [31:0] mag_of(input logic [31:0] a);
    return a[31] ? (~a + 32'd1) : a;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] a);
    logic [31:0] mag, mant, rem, half;
    int p, e, sh;
    if (a == 32'd0) return 32'd0;
    mag = mag_of(a);
    p = msb_pos(mag);
    e = p + 127;
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
      if (mant == 32'h0100_0000) begin
        mant = mant >> 1;
        e++;
      end
    end
    return {a[31], 8'(e), mant[22:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] a);
    if (a == 32'd0) return 2;
`ifdef ITOF_FAST_NORMALISE_EN
    return 5;
`else
    return 5 + (31 - msb_pos(mag_of(a)));
`endif
  endfunction

  // Done monitor: pops the oldest expectation on each done pulse
  always @(negedge clk) begin
    if (bus.done_strobe_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_z"}, bus.z_value_o, e.z);
        check({e.tag, "_lat"}, 32'(cyc - e.start - 1), 32'(e.lat));
      end
    end
  end

  // Drive a one-cycle exec strobe at the current negedge and queue the expectation
  task automatic start_op(input logic [31:0] a, input logic [31:0] z, input string tag);
    exp_t e;
    bus.a_value_i     = a;
    bus.exec_strobe_i = 1'b1;
    e.z     = z;
    e.start = cyc;
    e.lat   = exp_lat(a);
    e.tag   = tag;
    sb.push_back(e);
    @(negedge clk);
    bus.exec_strobe_i = 1'b0;
    bus.a_value_i     = $urandom;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] z, input string tag);
    @(negedge clk);
    start_op(a, z, tag);
    wait_drain(tag);
  endtask

  initial begin
    logic [31:0] ra;
    int n;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    reset_i           = 1'b1;
    bus.a_value_i     = 32'd0;
    bus.exec_strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_z", bus.z_value_o, 32'd0);
    check("rst_done", {31'd0, bus.done_strobe_o}, 32'd0);
    reset_i = 1'b0;

    // Directed vectors
    run_one(32'd1,          32'h3F80_0000, "one");
    run_one(32'hFFFF_FFFF,  32'hBF80_0000, "neg_one");
    run_one(32'd0,          32'h0000_0000, "zero");
    run_one(32'h8000_0000,  32'hCF00_0000, "int_min");
    run_one(32'd16777217,   32'h4B80_0000, "tie_even_dn");
    run_one(32'd16777219,   32'h4B80_0002, "tie_up");
    run_one(32'd16777221,   32'h4B80_0002, "tie_even_dn2");
    run_one(32'h7FFF_FFFF,  32'h4F00_0000, "carry");
    run_one(-32'sd100,      32'hC2C8_0000, "neg_100");

    // Random operands, plus a spread of magnitudes
    for (int i = 0; i < 24; i++) begin
      ra = $urandom >> (i % 32);
      if (i % 3 == 0) ra = ~ra + 32'd1;
      run_one(ra, ref_f(ra), $sformatf("rnd%0d", i));
    end

    // Exec while busy is ignored
    @(negedge clk);
    start_op(32'd1000, ref_f(32'd1000), "busy");
    @(negedge clk);
    bus.a_value_i     = 32'd7;
    bus.exec_strobe_i = 1'b1;
    @(negedge clk);
    bus.exec_strobe_i = 1'b0;
    wait_drain("busy");
    repeat (45) @(negedge clk);

    // Back-to-back: new exec in the done cycle
    @(negedge clk);
    start_op(32'd5, 32'h40A0_0000, "b2b_a");
    n = 0;
    while (!bus.done_strobe_o && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", {31'd0, bus.done_strobe_o}, 32'd1);
    start_op(-32'sd7, 32'hC0E0_0000, "b2b_b");
    check("b2b_gap", {31'd0, bus.done_strobe_o}, 32'd0);
    wait_drain("b2b");

    // Reset during NORMALISE abandons the conversion
    @(negedge clk);
    start_op(32'd1, 32'h3F80_0000, "rst_mid");
    repeat (4) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    sb.delete();
    check("rst_mid_z", bus.z_value_o, 32'd0);
    check("rst_mid_done", {31'd0, bus.done_strobe_o}, 32'd0);
    repeat (45) @(negedge clk);
    run_one(32'd3, 32'h4040_0000, "after_rst");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Multi-cycle converter from a signed 32-bit two's-complement integer to IEEE-754 single precision, round-to-nearest-even.
- Sits directly upstream of the FPU multiplier. It turns integer or fixed-point geometry and colour values into floats that feed the multiplier's a/b operands.
- Uses the same exec/done strobe handshake as the other FPU blocks, so a sequencer can chain conversion and multiply.

Parameters:
none

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_i  input  1  synchronous reset, active-high
a_value_i  input  32  signed two's-complement integer operand
z_value_o  output  32  IEEE-754 single-precision result
exec_strobe_i  input  1  start conversion; sampled only in IDLE
done_strobe_o  output  1  one-cycle pulse, result valid on z_value_o

Behaviour:
- Clock and reset: one clock, clk. reset_i is synchronous and active-high and takes priority over every other update in that cycle.
- Reset values: state=IDLE, done_strobe_o=0, z_value_o=32'h0. Reset mid-operation abandons the conversion and produces no done pulse.
- States: IDLE, CONVERT, NORMALISE, ROUND, PACK, DONE.
- IDLE:
  - done_strobe_o<=0.
  - If exec_strobe_i is high, register a_value_i into an internal operand register and go to CONVERT.
  - a_value_i is don't-care after that edge.
- CONVERT:
  - Operand == 0: z_value_o<=32'h0 (positive zero), go to DONE.
  - Otherwise: z_s<=operand[31]; z_m (32-bit unsigned)<=|operand|; z_e<=31; go to NORMALISE.
  - |0x80000000| is 0x80000000, treated as unsigned; no overflow.
- NORMALISE:
  - If z_m[31]==0: z_m<=z_m<<1, z_e<=z_e-1, stay in NORMALISE.
  - Else go to ROUND.
  - Takes lz+1 cycles, where lz = leading zeros of |operand| (0..31).
- ROUND:
  - Mantissa m=z_m[31:8], guard=z_m[7], round=z_m[6], sticky=|z_m[5:0].
  - If guard && (round | sticky | m[0]): m<=m+1.
  - If m==24'hFFFFFF before the increment: m wraps to 0 and z_e<=z_e+1.
  - Go to PACK.
- PACK:
  - z_value_o<={z_s, z_e[7:0]+8'd127, m[22:0]}.
  - z_e ranges 0..31, so no overflow, infinity or denormal case exists.
  - Go to DONE.
- DONE: done_strobe_o<=1; state<=IDLE.
- Latency: done_strobe_o is high in the cycle following edge N, where edge 0 is the edge that samples exec_strobe_i.
  - Nonzero operand: N = 5+lz.
  - Zero operand: N = 2.
- Result hold: z_value_o is written only in CONVERT (zero case) and PACK. It holds the last result until the next completion or reset.
- Back-to-back: exec_strobe_i asserted in the cycle done_strobe_o is high starts a new conversion, since the state is already IDLE. That edge also clears done_strobe_o.
- Busy: exec_strobe_i in any state other than IDLE is ignored and is not queued.
- Width rules: z_e is a signed 6-bit register or wider; the mantissa increment is 24-bit with wrap detection.

Optional Feature:
- Macro: ITOF_FAST_NORMALISE_EN
- Defined:
  - NORMALISE is a single cycle: a combinational 32-bit leading-zero count drives z_m<=z_m<<lz and z_e<=31-lz, then the block goes to ROUND.
  - Latency is a fixed N=5 for nonzero operands; zero stays N=2.
- Undefined: iterative one-bit-per-cycle shift as described in Behaviour.
- Results are bit-identical in both builds.

Test Plan:
- a=1 -> z=0x3F800000; done at N=36 (N=5 with ITOF_FAST_NORMALISE_EN). a=-1 -> z=0xBF800000, same latency.
- a=0 -> z=0x00000000, done at N=2. a=0x80000000 -> z=0xCF000000, N=5.
- Rounding ties: a=16777217 -> 0x4B800000 (tie, round to even, down). a=16777219 -> 0x4B800002 (tie, round up). a=16777221 -> 0x4B800002 (tie, round to even, down).
- Mantissa carry: a=0x7FFFFFFF -> 0x4F000000 (exponent bump). a=-100 -> 0xC2C80000.
- Handshake:
  - Pulse exec_strobe_i again 3 cycles after start -> ignored, exactly one done pulse, result from the first operand.
  - Exec in the done cycle -> second result correct, done_strobe_o low for at least one cycle between the pulses.
- Reset: assert reset_i during NORMALISE -> next cycle done_strobe_o=0, z_value_o=0, state IDLE, no done pulse. A following conversion of a=3 -> 0x40400000.
